pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It drives the hold/flush inputs of the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards and branches resolved in EX, and redirects for jumps resolved in ID.
- Owns a multi-cycle mult/div occupancy timer that stalls dependent or back-to-back HI/LO instructions.
- Keeps saturating bubble/flush performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl_md_busy_timer.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   MDU_LAT_DEF : default mult/div busy latency in cycles
//   REG_ZERO    : register $0, which never creates a dependency
//   hz_e        : hazard classes, listed lowest to highest priority
package pipe_ctrl_pkg;
    localparam int unsigned MDU_LAT_DEF = 4;
    localparam logic [4:0]  REG_ZERO    = 5'd0;

    typedef enum logic [2:0] {
        HZ_NONE,
        HZ_JUMP,
        HZ_STALL,
        HZ_BRANCH,
        HZ_RESET
    } hz_e;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of the hazard controller's pipeline-facing signals.
//   ID/EX decode inputs : rs_ID, rt_ID, UseRs_ID, UseRt_ID, MemRead_EX, rt_EX,
//                         BranchTaken_EX, Jump_ID, MdStart_ID, MdRead_ID
//   control outputs     : hold_PC, hold_IFID, flush_IFID, flush_IDEX, md_start
//   status outputs      : md_busy, stall_cnt, flush_cnt
// master = the pipeline side that drives decode info; slave = the controller.
interface pipe_hazard_ctrl_if #(parameter int unsigned CNT_W = 32);
    logic [4:0]       rs_ID;
    logic [4:0]       rt_ID;
    logic             UseRs_ID;
    logic             UseRt_ID;
    logic             MemRead_EX;
    logic [4:0]       rt_EX;
    logic             BranchTaken_EX;
    logic             Jump_ID;
    logic             MdStart_ID;
    logic             MdRead_ID;
    logic             hold_PC;
    logic             hold_IFID;
    logic             flush_IFID;
    logic             flush_IDEX;
    logic             md_start;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs_ID, rt_ID, UseRs_ID, UseRt_ID, MemRead_EX, rt_EX,
               BranchTaken_EX, Jump_ID, MdStart_ID, MdRead_ID,
        input  hold_PC, hold_IFID, flush_IFID, flush_IDEX, md_start,
               md_busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_ID, rt_ID, UseRs_ID, UseRt_ID, MemRead_EX, rt_EX,
               BranchTaken_EX, Jump_ID, MdStart_ID, MdRead_ID,
        output hold_PC, hold_IFID, flush_IFID, flush_IDEX, md_start,
               md_busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Mult/div occupancy timer. Loads MDU_LAT when an op enters EX and counts
// down to zero; md_busy_o is high while the count is nonzero.
//   clk, reset : clock, synchronous active-high reset
//   start_i    : mult/div op accepted this cycle
//   md_busy_o  : timer nonzero
//   md_cnt_o   : remaining busy cycles
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = MDU_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    output logic       md_busy_o,
    output logic [3:0] md_cnt_o
);
    localparam logic [3:0] LAT = 4'(MDU_LAT);

    logic [3:0] md_cnt_q, md_cnt_d;

    // A new start wins over the decrement; the controller never issues a
    // start while busy, so this only matters on the cycle the count hits 0.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (start_i)
            md_cnt_d = LAT;
        else if (md_cnt_q != 4'd0)
            md_cnt_d = md_cnt_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            md_cnt_q <= 4'd0;
        else
            md_cnt_q <= md_cnt_d;
    end

    assign md_busy_o = (md_cnt_q != 4'd0);
    assign md_cnt_o  = md_cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core. Decodes
// load-use and mult/div hazards, EX branch and ID jump redirects, and
// drives the PC / IF/ID / ID/EX hold and flush controls.
//   clk, reset : clock, synchronous active-high reset
//   hz         : decode inputs, control outputs and perf counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = MDU_LAT_DEF,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_ctrl_if.slave   hz
);
    logic       lu, mds, stall, md_start, md_busy;
    logic [3:0] md_cnt;
    hz_e        hz_sel;
    logic       hold_pc, hold_ifid, flush_ifid, flush_idex;
    logic       stall_inc, flush_inc;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // A load into $0 never produces a value, so it cannot cause a stall.
    assign lu = hz.MemRead_EX && (hz.rt_EX != REG_ZERO) &&
                ((hz.UseRs_ID && (hz.rs_ID == hz.rt_EX)) ||
                 (hz.UseRt_ID && (hz.rt_ID == hz.rt_EX)));
    assign mds   = md_busy && (hz.MdStart_ID || hz.MdRead_ID);
    assign stall = lu || mds;

    // A taken branch kills the ID instruction, so its stall is moot.
    assign md_start = hz.MdStart_ID && !stall && !hz.BranchTaken_EX && !reset;

    always_comb begin
        hz_sel = HZ_NONE;
        if (reset)                  hz_sel = HZ_RESET;
        else if (hz.BranchTaken_EX) hz_sel = HZ_BRANCH;
        else if (stall)             hz_sel = HZ_STALL;
        else if (hz.Jump_ID)        hz_sel = HZ_JUMP;
    end

    always_comb begin
        hold_pc    = 1'b0;
        hold_ifid  = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        case (hz_sel)
            HZ_RESET, HZ_BRANCH: begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end
            HZ_STALL: begin
                hold_pc    = 1'b1;
                hold_ifid  = 1'b1;
                flush_idex = 1'b1;
            end
            HZ_JUMP:  flush_ifid = 1'b1;
            default:  ;
        endcase
    end

    md_busy_timer #(.MDU_LAT(MDU_LAT)) u_md_timer (
        .clk       (clk),
        .reset     (reset),
        .start_i   (md_start),
        .md_busy_o (md_busy),
        .md_cnt_o  (md_cnt)
    );

    // Counters stick at all-ones instead of wrapping.
    assign stall_inc = stall && !hz.BranchTaken_EX;
    assign flush_inc = hz.BranchTaken_EX || (hz.Jump_ID && !stall);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_inc && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.hold_PC    = hold_pc;
    assign hz.hold_IFID  = hold_ifid;
    assign hz.flush_IFID = flush_ifid;
    assign hz.flush_IDEX = flush_idex;
    assign hz.md_start   = md_start;
    assign hz.md_busy    = md_busy;
    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.flush_cnt  = flush_cnt_q;

    logic unused_ok;
    assign unused_ok = ^md_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl with a behavioural
// reference model (remaining-busy-cycle count plus saturating tallies).
module tb_pipe_hazard_ctrl;
    localparam int unsigned LAT = 4;
    localparam longint      SAT = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(32)) hz ();

    pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int     vectors = 0;
    int     errors  = 0;
    int     m_left  = 0;      // cycles the MDU is still occupied
    longint m_stall = 0;
    longint m_flush = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hz.rs_ID = 0; hz.rt_ID = 0; hz.UseRs_ID = 0; hz.UseRt_ID = 0;
        hz.MemRead_EX = 0; hz.rt_EX = 0; hz.BranchTaken_EX = 0;
        hz.Jump_ID = 0; hz.MdStart_ID = 0; hz.MdRead_ID = 0;
    endtask

    // Check all outputs for the current inputs, then clock once and advance
    // the model from the rules: reset > branch kill > stall > jump.
    task automatic step(input string tag);
        bit dep, md_wait, stl, e_hpc, e_hif, e_fif, e_fid, e_start;
        #1;
        dep = hz.MemRead_EX && hz.rt_EX != 0 &&
              ((hz.UseRs_ID && hz.rs_ID == hz.rt_EX) || (hz.UseRt_ID && hz.rt_ID == hz.rt_EX));
        md_wait = (m_left > 0) && (hz.MdStart_ID || hz.MdRead_ID);
        stl = dep || md_wait;
        e_hpc = 0; e_hif = 0; e_fif = 0; e_fid = 0;
        if (reset || hz.BranchTaken_EX) begin e_fif = 1; e_fid = 1; end
        else if (stl) begin e_hpc = 1; e_hif = 1; e_fid = 1; end
        else if (hz.Jump_ID) e_fif = 1;
        e_start = hz.MdStart_ID && !stl && !hz.BranchTaken_EX && !reset;
        chk({tag, ".hold_PC"},    32'(hz.hold_PC),    32'(e_hpc));
        chk({tag, ".hold_IFID"},  32'(hz.hold_IFID),  32'(e_hif));
        chk({tag, ".flush_IFID"}, 32'(hz.flush_IFID), 32'(e_fif));
        chk({tag, ".flush_IDEX"}, 32'(hz.flush_IDEX), 32'(e_fid));
        chk({tag, ".md_start"},   32'(hz.md_start),   32'(e_start));
        chk({tag, ".md_busy"},    32'(hz.md_busy),    32'(m_left > 0));
        chk({tag, ".stall_cnt"},  hz.stall_cnt,       m_stall[31:0]);
        chk({tag, ".flush_cnt"},  hz.flush_cnt,       m_flush[31:0]);
        @(posedge clk);
        if (reset) begin
            m_left = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (e_start) m_left = LAT;
            else if (m_left > 0) m_left--;
            if (stl && !hz.BranchTaken_EX && m_stall < SAT) m_stall++;
            if ((hz.BranchTaken_EX || (hz.Jump_ID && !stl)) && m_flush < SAT) m_flush++;
        end
        #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1;
        step("rst");
        reset = 0;
    endtask

    initial begin
        int stalls;
        reset = 1; idle();
        @(posedge clk); #1;
        m_left = 0; m_stall = 0; m_flush = 0;
        // Reset state with a mult in ID: still no md_start.
        hz.MdStart_ID = 1;
        step("reset");
        reset = 0; idle();
        step("post_reset");

        // Load-use on rs.
        hz.MemRead_EX = 1; hz.rt_EX = 8; hz.rs_ID = 8; hz.UseRs_ID = 1;
        step("loaduse");
        idle();
        step("loaduse_after");
        chk("loaduse_cnt", hz.stall_cnt, 32'd1);

        // Load to $0 never stalls.
        hz.MemRead_EX = 1; hz.rt_EX = 0; hz.rs_ID = 0; hz.UseRs_ID = 1;
        step("load_r0");
        idle();

        // Load-use on rt, then a jump.
        hz.MemRead_EX = 1; hz.rt_EX = 5; hz.rt_ID = 5; hz.UseRt_ID = 1;
        step("loaduse_rt");
        idle(); hz.Jump_ID = 1;
        step("jump");
        idle();

        // mult then mfhi: four stall cycles, issues on the fifth.
        do_reset();
        hz.MdStart_ID = 1;
        step("mult");
        hz.MdStart_ID = 0; hz.MdRead_ID = 1;
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!hz.hold_PC) break;
            stalls++;
            step("mfhi_wait");
        end
        chk("mfhi_stalls", 32'(stalls), 32'd4);
        step("mfhi_go");
        chk("mfhi_stall_cnt", hz.stall_cnt, 32'd4);
        idle();

        // Branch overrides a load-use stall.
        hz.BranchTaken_EX = 1; hz.MemRead_EX = 1; hz.rt_EX = 9; hz.rs_ID = 9; hz.UseRs_ID = 1;
        step("br_over_stall");
        idle();
        step("br_after");
        chk("br_flush_cnt", hz.flush_cnt, 32'd1);

        // Branch does not clear the MD timer.
        hz.MdStart_ID = 1;
        step("mult2");
        idle(); hz.BranchTaken_EX = 1;
        step("br_md");
        idle();
        step("br_md_busy");

        // Reset mid-MD operation.
        do_reset();
        hz.MdStart_ID = 1;
        step("mult3");
        idle();
        step("md_cnt3");
        reset = 1;
        step("rst_mid_md");
        reset = 0;
        step("rst_mid_after");
        chk("rst_md_busy", 32'(hz.md_busy), 32'd0);

        // Saturation of stall_cnt.
        force u_dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release u_dut.stall_cnt_q;
        m_stall = SAT;
        hz.MemRead_EX = 1; hz.rt_EX = 3; hz.rs_ID = 3; hz.UseRs_ID = 1;
        step("sat");
        idle();
        step("sat_after");
        chk("sat_cnt", hz.stall_cnt, 32'hFFFF_FFFF);

        // Randomized traffic; small register range to make matches common.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            hz.rs_ID          = 5'($urandom_range(0, 3));
            hz.rt_ID          = 5'($urandom_range(0, 3));
            hz.rt_EX          = 5'($urandom_range(0, 3));
            hz.UseRs_ID       = 1'($urandom_range(0, 1));
            hz.UseRt_ID       = 1'($urandom_range(0, 1));
            hz.MemRead_EX     = ($urandom_range(0, 99) < 40);
            hz.BranchTaken_EX = ($urandom_range(0, 99) < 12);
            hz.Jump_ID        = ($urandom_range(0, 99) < 15);
            hz.MdStart_ID     = ($urandom_range(0, 99) < 25);
            hz.MdRead_ID      = ($urandom_range(0, 99) < 25);
            reset             = ($urandom_range(0, 99) < 3);
            step("rand");
        end
        reset = 0; idle();
        step("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
